controlador_acceso_memoria: RTL and testbench
=============================================

Name: controlador_acceso_memoria

Overview:
- Initiator side of the word-wide data memory interface (read/write/direccion/din/dout, memory samples on negedge clk).
- Sits in the MEM pipeline stage.
- Accepts byte/halfword/word load and store requests from the pipeline and converts them into word accesses. Sub-word stores use read-modify-write.
- Returns formatted load data, and asserts stall to the pipeline until each access completes.

Parameters:
- ADDR_W, 10, word-address width driven to the memory; uses req_addr[ADDR_W+1:2].
- DATA_W, 32, memory word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  in  1  request present; the pipeline holds all req_* stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  combinational; hold the pipeline.
- resp_valid  out  1  registered; one-cycle completion pulse.
- resp_rdata  out  32  registered load result.
- resp_err  out  1  registered; misaligned access flag, valid with resp_valid.
- mem_read  out  1  registered read strobe to the memory.
- mem_write  out  1  registered write strobe to the memory.
- mem_dir  out  ADDR_W  registered word address.
- mem_din  out  32  registered write data.
- mem_dout  in  32  memory read data, valid after the negedge on which mem_read was high.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; resp_valid, resp_err, mem_read, mem_write=0; resp_rdata, mem_dir, mem_din=0.
  - Reset mid-operation aborts the access and clears strobes at that edge, so no memory write occurs on the following negedge.
  - A write already performed on an earlier negedge stands.
- Lane and endianness rules: little-endian.
  - Byte lane = addr[1:0] (lane 0 = bits 7:0).
  - Halfword lane = addr[1] (0 = bits 15:0).
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Address range: addr bits above ADDR_W+1 are ignored (aliasing).
- States: IDLE, LOAD, RMW_RD, DONE.
- IDLE with req_valid=1:
  - Misaligned: no strobes; resp_err<=1, resp_rdata<=0; ->DONE.
  - Word store: mem_write<=1, mem_din<=req_wdata, mem_dir<=addr; ->DONE.
  - Load: mem_read<=1, mem_dir<=addr; ->LOAD.
  - Byte/half store: mem_read<=1, mem_dir<=addr; ->RMW_RD.
- IDLE with req_valid=0: stay in IDLE; strobes 0.
- LOAD: mem_read<=0; resp_rdata<=lane extracted from mem_dout, then zero- or sign-extended per req_signed (word: unchanged); ->DONE.
- RMW_RD: mem_read<=0; mem_write<=1; mem_din<=mem_dout with the selected lane replaced by req_wdata[7:0] or [15:0]; ->DONE.
- DONE: resp_valid=1 for exactly this cycle.
  - The write strobe, if set, is active here and the memory writes on this cycle's negedge.
  - Next posedge: mem_write, mem_read, resp_valid, resp_err<=0; ->IDLE.
  - The next request can be accepted at the following posedge, so there is at least one IDLE cycle between back-to-back requests.
- stall = (state==IDLE && req_valid) || state==LOAD || state==RMW_RD. stall=0 in DONE, so the pipeline advances at the posedge ending DONE.
- Cycles from first req_valid cycle to resp_valid (inclusive):
  - Word store or misaligned access: 2.
  - Load or sub-word store: 3.
- req_valid dropping after acceptance does not cancel the operation; resp_valid still pulses.
- mem_read and mem_write are never both 1 in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> all outputs 0, no strobes. Release -> first access begins on the next edge.
- Word store then load at 0x10: store 0xDEADBEEF -> mem_write=1 for one cycle with mem_dir=4, resp_valid in cycle 2. Load -> mem_read for one cycle, resp_rdata=0xDEADBEEF in cycle 3, stall high cycles 1-2.
- Byte store 0xAA to 0x13 over word 0x11223344 -> mem_din=0xAA223344, single write. Subsequent signed byte load at 0x13 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword load at 0x12, word 0x8001_7FFF -> signed 0xFFFF8001, unsigned 0x00008001. Halfword at 0x10 signed -> 0x00007FFF.
- Misaligned halfword store at 0x11 -> no mem_read/mem_write, resp_err=1, resp_valid in cycle 2, memory unchanged.
- rst_n=0 at the posedge entering RMW_RD->DONE of a byte store -> mem_write never asserted, target word unchanged, state IDLE.

Source files
------------

// File: rtl/controlador_acceso_memoria.sv
// controlador_acceso_memoria
//   Initiator side of the word-wide data memory interface for the MEM stage.
//   Turns byte/halfword/word loads and stores from the pipeline into word
//   accesses. Sub-word stores use read-modify-write. Load data is returned
//   formatted, and stall holds the pipeline until the access completes.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/we/size/signed/addr/wdata   pipeline request (held while stall)
//   stall             combinational pipeline hold
//   resp_valid/rdata/err                  registered one-cycle completion
//   mem_read/write/dir/din                registered memory strobes, word address, write data
//   mem_dout          memory read data (valid after the negedge with mem_read high)
module controlador_acceso_memoria #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, DONE} state_t;

  state_t      state;

  // Request fields captured at acceptance, so the operation completes even if
  // req_valid drops after the first cycle.
  logic [1:0]  op_size;
  logic        op_signed;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic        is_byte, is_half, is_word, misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] lane_mask;
  logic [4:0]        lane_shift;

  // Address bits above the word address alias; bits 1:0 select the lane.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign is_byte    = (req_size == 2'b00);
  assign is_half    = (req_size == 2'b01);
  assign is_word    = req_size[1];
  assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));

  assign stall = ((state == IDLE) && req_valid) || (state == LOAD) || (state == RMW_RD);

  // Lane extraction and sign/zero extension for loads (little-endian).
  always_comb begin
    lane_byte = '0;
    lane_half = '0;
    load_data = mem_dout;
    case (op_lane)
      2'd0:    lane_byte = mem_dout[7:0];
      2'd1:    lane_byte = mem_dout[15:8];
      2'd2:    lane_byte = mem_dout[23:16];
      default: lane_byte = mem_dout[31:24];
    endcase
    lane_half = op_lane[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (op_size)
      2'b00:   load_data = {{24{op_signed & lane_byte[7]}}, lane_byte};
      2'b01:   load_data = {{16{op_signed & lane_half[15]}}, lane_half};
      default: load_data = mem_dout;
    endcase
  end

  // Read-modify-write merge: replace only the selected lane of the read word.
  always_comb begin
    lane_shift = {op_lane, 3'b000};
    lane_mask  = (op_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    merged     = (mem_dout & ~(lane_mask << lane_shift)) |
                 (({16'h0000, op_wdata} & lane_mask) << lane_shift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_dir    <= '0;
      mem_din    <= '0;
      op_size    <= '0;
      op_signed  <= 1'b0;
      op_lane    <= '0;
      op_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            op_size   <= req_size;
            op_signed <= req_signed;
            op_lane   <= req_addr[1:0];
            op_wdata  <= req_wdata[15:0];
            if (misaligned) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (req_we && is_word) begin
              mem_write  <= 1'b1;
              mem_din    <= req_wdata;
              mem_dir    <= req_addr[ADDR_W+1:2];
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              mem_read <= 1'b1;
              mem_dir  <= req_addr[ADDR_W+1:2];
              state    <= (req_we && (is_byte || is_half)) ? RMW_RD : LOAD;
            end
          end
        end
        LOAD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        RMW_RD: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b1;
          mem_din    <= merged;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_acceso_memoria.sv
module tb_controlador_acceso_memoria;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_dir;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controlador_acceso_memoria #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dir(mem_dir), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Word memory acting on the negedge.
  logic [31:0] mem [0:(1<<AW)-1];
  int unsigned wr_total = 0;
  int unsigned both_cnt = 0;
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      mem[mem_dir] <= mem_din;
      wr_total     <= wr_total + 1;
    end
    if (mem_read === 1'b1) mem_dout <= mem[mem_dir];
    if (mem_read === 1'b1 && mem_write === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: the effect of one request from the access rules alone.
  function automatic void ref_op(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 inout logic [31:0] word, output logic [31:0] rdata,
                                 output logic err, output int lat, output int nrd,
                                 output int nwr);
    int unsigned nb, sh;
    longint unsigned fmask, w, v;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (addr % nb) != 0;
    sh    = 8 * (addr % 4);
    fmask = (64'd1 << (8 * nb)) - 1;
    rdata = '0; lat = 2; nrd = 0; nwr = 0;
    if (err) return;
    if (we) begin
      nwr = 1;
      if (nb != 4) begin lat = 3; nrd = 1; end
      w = 64'(word);
      w = (w & ~(fmask << sh)) | ((64'(wdata) & fmask) << sh);
      word = w[31:0];
    end else begin
      lat = 3; nrd = 1;
      v = (64'(word) >> sh) & fmask;
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~fmask;
      rdata = v[31:0];
    end
  endfunction

  // Issues one request starting at posedge+1, returns at posedge+1 of the next IDLE cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit drop,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr, output bit dir_ok, output bit stall_ok);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    lat = 1; nrd = 0; nwr = 0; dir_ok = 1; stall_ok = 1; rdata = 'x; err = 1'bx;
    #1;
    forever begin
      if (mem_read === 1'b1) nrd++;
      if (mem_write === 1'b1) nwr++;
      if ((mem_read === 1'b1 || mem_write === 1'b1) && mem_dir !== addr[AW+1:2]) dir_ok = 0;
      if (resp_valid === 1'b1) begin
        if (stall !== 1'b0) stall_ok = 0;
        rdata = resp_rdata; err = resp_err;
        break;
      end
      if (stall !== 1'b1) stall_ok = 0;
      if (lat >= 8) break;
      @(posedge clk); #2;
      lat++;
      if (drop && lat == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [31:0] rd, wsave, eword, erd;
    logic        er, eer;
    int          lat, nrd, nwr, elat, enrd, enwr;
    bit          dok, sok;
    logic [AW-1:0] wi;
    logic [31:0] r_mem [0:(1<<AW)-1];
    int unsigned wr_before;

    tbl[0]  = '{1'b1, 2'd0 + 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0, 2};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h13,   32'h000000AA, 32'h0,        1'b0, 3};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hAA223344, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFFAA, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h000000AA, 1'b0, 3};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h80017FFF, 32'h0,        1'b0, 2};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFF8001, 1'b0, 3};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h00008001, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        32'h00007FFF, 1'b0, 3};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h11,   32'h00001234, 32'h0,        1'b1, 2};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h80017FFF, 1'b0, 3};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1, 2};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h1010, 32'h12345678, 32'h0,        1'b0, 2};
    tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h12345678, 1'b0, 3};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h0000BEEF, 32'h0,        1'b0, 3};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hBEEF5678, 1'b0, 3};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'h00000056, 1'b0, 3};
    tbl[19] = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFFBE, 1'b0, 3};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[4] = 32'h5A5A1234;

    // Reset held with a request pending: registered outputs stay cleared.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", {resp_valid, resp_err, mem_read, mem_write, 28'h0} | resp_rdata | mem_din | 32'(mem_dir), 32'h0);
    @(posedge clk); #1;
    chk("reset_outputs_b", {resp_valid, resp_err, mem_read, mem_write, 28'h0} | resp_rdata | mem_din | 32'(mem_dir), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_read", 32'(mem_read), 32'd1);
    chk("post_reset_dir", 32'(mem_dir), 32'd4);
    chk("post_reset_nowrite", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("post_reset_resp", 32'(resp_valid), 32'd1);
    chk("post_reset_rdata", resp_rdata, 32'h5A5A1234);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(resp_valid), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 20; i++) begin
      do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, 1'b0,
             rd, er, lat, nrd, nwr, dok, sok);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      if (!tbl[i].we || tbl[i].exp_err) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(tbl[i].we && !tbl[i].exp_err));
      chk($sformatf("vec%0d_reads", i), 32'(nrd),
          32'(!tbl[i].exp_err && (!tbl[i].we || !tbl[i].size[1])));
      chk($sformatf("vec%0d_dir", i), 32'(dok), 32'd1);
      chk($sformatf("vec%0d_stall", i), 32'(sok), 32'd1);
    end

    // Reset arriving while a byte store sits in its read phase.
    mem[8] = 32'hCAFEF00D;
    wr_before = wr_total;
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("rmw_reset_read_phase", 32'(mem_read), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_reset_nowrite", 32'(mem_write), 32'd0);
    chk("rmw_reset_noresp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmw_reset_writes", 32'(wr_total), 32'(wr_before));
    chk("rmw_reset_mem", mem[8], 32'hCAFEF00D);
    chk("rmw_reset_stall", 32'(stall), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, nrd, nwr, dok, sok);
    chk("rmw_reset_idle_latency", 32'(lat), 32'd3);
    chk("rmw_reset_idle_rdata", rd, 32'hCAFEF00D);

    // Randomized requests against the reference.
    for (int i = 0; i < (1 << AW); i++) r_mem[i] = mem[i];
    for (int n = 0; n < 300; n++) begin
      logic        we, sgn, drop;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      drop  = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      wdata = $urandom;
      wi    = addr[AW+1:2];
      eword = r_mem[wi];
      ref_op(we, size, sgn, addr, wdata, eword, erd, eer, elat, enrd, enwr);
      r_mem[wi] = eword;
      do_req(we, size, sgn, addr, wdata, drop, rd, er, lat, nrd, nwr, dok, sok);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(eer));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
      if (!we || eer) chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_reads", n), 32'(nrd), 32'(enrd));
      chk($sformatf("rnd%0d_writes", n), 32'(nwr), 32'(enwr));
      chk($sformatf("rnd%0d_dir", n), 32'(dok), 32'd1);
      chk($sformatf("rnd%0d_stall", n), 32'(sok), 32'd1);
      wsave = mem[wi];
      chk($sformatf("rnd%0d_mem", n), wsave, r_mem[wi]);
    end

    chk("strobes_never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
